bus_bridge: RTL

- Parametrised data-side bus bridge between the single-cycle RISC-V core and its memory-mapped targets.
- Decodes each load/store to either DRAM (zero-wait pass-through) or one of N_DEV peripheral slots (switches, LEDs, timers, ...).
- Peripheral accesses use a req/ack handshake with a timeout.
- Drives a stall that the core ANDs into its PC enable; replaces the fixed LED/switch wiring at the CPU top.

---
 rtl/bus_pkg.sv | 17 +
 rtl/bus_addr_decode.sv | 19 +
 rtl/bus_bridge.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the data- and instruction-side bus bridges.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEV_WAIT = 2'd1,
    DONE     = 2'd2
  } state_e;

  localparam int unsigned SLOT_SHIFT   = 8;
  localparam int unsigned REGION_SHIFT = 12;
  localparam int unsigned SLOT_W       = REGION_SHIFT - SLOT_SHIFT;

  localparam logic [31:0] DEF_DEV_BASE  = 32'hFFFF_F000;
  localparam logic [31:0] DEF_ERR_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational decode of a byte address into peripheral hit, slot number and unmapped-slot flag.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       N_DEV    = 4,
  parameter logic [ADDR_W-1:0] DEV_BASE = ADDR_W'(DEF_DEV_BASE)
) (
  input  logic [ADDR_W-1:SLOT_SHIFT] addr_i,
  output logic                       dev_hit_o,
  output logic [SLOT_W-1:0]          slot_o,
  output logic                       bad_slot_o
);

  assign dev_hit_o  = (addr_i[ADDR_W-1:REGION_SHIFT] == DEV_BASE[ADDR_W-1:REGION_SHIFT]);
  assign slot_o     = addr_i[REGION_SHIFT-1:SLOT_SHIFT];
  assign bad_slot_o = dev_hit_o && (32'(slot_o) >= N_DEV);

endmodule

// File: rtl/bus_bridge.sv
// Data-side bridge: zero-wait DRAM pass-through or req/ack peripheral slots with timeout and stall.
// Define BUS_PERF_CNT_EN to build the stall-cycle and error performance counters.
module bus_bridge
  import bus_pkg::*;
#(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       N_DEV     = 4,
  parameter logic [ADDR_W-1:0] DEV_BASE  = ADDR_W'(DEF_DEV_BASE),
  parameter int unsigned       TIMEOUT   = 15,
  parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(DEF_ERR_RDATA)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_stall,
  output logic                    cpu_err,
  output logic                    dram_we,
  output logic [ADDR_W-1:0]       dram_addr,
  output logic [DATA_W-1:0]       dram_wdata,
  input  logic [DATA_W-1:0]       dram_rdata,
  output logic [N_DEV-1:0]        dev_sel,
  output logic                    dev_we,
  output logic [7:0]              dev_addr,
  output logic [DATA_W-1:0]       dev_wdata,
  input  logic [N_DEV*DATA_W-1:0] dev_rdata,
  input  logic [N_DEV-1:0]        dev_ack,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_to_cnt
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic              dev_hit;
  logic              bad_slot;
  logic [SLOT_W-1:0] slot;

  bus_addr_decode #(
    .ADDR_W   (ADDR_W),
    .N_DEV    (N_DEV),
    .DEV_BASE (DEV_BASE)
  ) u_decode (
    .addr_i     (cpu_addr[ADDR_W-1:SLOT_SHIFT]),
    .dev_hit_o  (dev_hit),
    .slot_o     (slot),
    .bad_slot_o (bad_slot)
  );

  state_e            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              we_q, we_d;
  logic [7:0]        addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [N_DEV-1:0]  sel_c;
  logic [DATA_W-1:0] sel_rdata_c;
  logic              ack_c;

  // One-hot of the latched slot and its read-data lane
  always_comb begin
    sel_c       = '0;
    sel_rdata_c = '0;
    for (int unsigned k = 0; k < N_DEV; k++) begin
      if (slot_q == SLOT_W'(k)) begin
        sel_c[k]    = 1'b1;
        sel_rdata_c = dev_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign ack_c = |(dev_ack & sel_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next state; an ack in the final wait cycle beats the timeout
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cap_d     = cap_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    cpu_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req && dev_hit) begin
          cpu_stall = 1'b1;
          cnt_d     = '0;
          if (bad_slot) begin
            state_d = DONE;
            cap_d   = ERR_RDATA;
            err_d   = 1'b1;
          end else begin
            state_d = DEV_WAIT;
            slot_d  = slot;
            we_d    = cpu_we;
            addr_d  = cpu_addr[SLOT_SHIFT-1:0];
            wdata_d = cpu_wdata;
            err_d   = 1'b0;
          end
        end
      end
      DEV_WAIT: begin
        cpu_stall = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (ack_c) begin
          state_d = DONE;
          cap_d   = sel_rdata_c;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          cap_d   = ERR_RDATA;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dram_addr  = cpu_addr;
  assign dram_wdata = cpu_wdata;
  assign dram_we    = cpu_req & cpu_we & ~dev_hit & (state_q == IDLE);

  assign dev_sel    = (state_q == DEV_WAIT) ? sel_c : '0;
  assign dev_we     = (state_q == DEV_WAIT) & we_q;
  assign dev_addr   = addr_q;
  assign dev_wdata  = wdata_q;

  assign cpu_rdata  = (state_q == DONE) ? cap_q : dram_rdata;
  assign cpu_err    = (state_q == DONE) & err_q;

`ifdef BUS_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_to_q    <= '0;
    end else begin
      if (cpu_stall) perf_stall_q <= perf_stall_q + 32'd1;
      if (cpu_err)   perf_to_q    <= perf_to_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_to_cnt    = perf_to_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_to_cnt    = '0;
`endif

endmodule
